// File: rtl/data_normalizer_auto.sv
// rtl/data_normalizer_auto.sv - frame normaliser: signed samples to unsigned pixels with auto min/range
//
// divu_int ports:
//   clk_i, rst_i (async, active-high), start_i, a_i / b_i (dividend / divisor),
//   done_o (one-cycle pulse), valid_o (0 on divide by zero), q_o (quotient).
//
// data_normalizer_auto ports:
//   i_clk, i_rst_n (async, active-low)
//   i_start, i_auto, i_min, i_range   frame start and manual scaling inputs (used only at start)
//   o_busy, o_done                    frame status
//   o_rd_valid, o_rd_addr, i_rd_data  frame RAM read port (data RD_LAT cycles after request)
//   o_wr_valid, o_wr_addr, o_wr_data  pixel RAM write port
//   o_min, o_range                    scaling used for the current/last frame
//   o_clip_lo, o_clip_hi              sticky per-frame clip indicators

module divu_int #(
    parameter int WIDTH = 20
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] q_o
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] q_q, q_d, r_q, r_d, b_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, done_q, valid_q;
    logic [WIDTH:0]   r_sh, r_diff;

    // Restoring division, one quotient bit per cycle. r_sh - b always lies in
    // (-b, b), so bit WIDTH of the difference is a reliable sign bit.
    always_comb begin
        r_sh   = {r_q, q_q[WIDTH-1]};
        r_diff = r_sh - {1'b0, b_q};
        if (r_diff[WIDTH]) begin
            r_d = r_sh[WIDTH-1:0];
            q_d = {q_q[WIDTH-2:0], 1'b0};
        end else begin
            r_d = r_diff[WIDTH-1:0];
            q_d = {q_q[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q     <= '0;
            r_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i && !busy_q) begin
                valid_q <= 1'b0;
                if (b_i == '0) begin
                    q_q    <= '0;
                    done_q <= 1'b1;
                end else begin
                    q_q    <= a_i;
                    r_q    <= '0;
                    b_q    <= b_i;
                    cnt_q  <= CW'(WIDTH);
                    busy_q <= 1'b1;
                end
            end else if (busy_q) begin
                q_q   <= q_d;
                r_q   <= r_d;
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign done_o  = done_q;
    assign valid_o = valid_q;
    assign q_o     = q_q;
endmodule

module data_normalizer_auto #(
    parameter int DATAW     = 16,
    parameter int DEPTH     = 768,
    parameter int OUTW      = 8,
    parameter int FRACTIONW = 12,
    parameter int RD_LAT    = 1,
    parameter int MIN_RANGE = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic                     i_auto,
    input  logic [DATAW-1:0]         i_min,
    input  logic [DATAW-1:0]         i_range,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_rd_valid,
    output logic [$clog2(DEPTH)-1:0] o_rd_addr,
    input  logic [DATAW-1:0]         i_rd_data,
    output logic                     o_wr_valid,
    output logic [$clog2(DEPTH)-1:0] o_wr_addr,
    output logic [OUTW-1:0]          o_wr_data,
    output logic [DATAW-1:0]         o_min,
    output logic [DATAW-1:0]         o_range,
    output logic                     o_clip_lo,
    output logic                     o_clip_hi
);
    localparam int ADDRW = $clog2(DEPTH);
    localparam int DIVW  = OUTW + FRACTIONW;
    localparam int PRODW = DATAW + DIVW + 1;
    localparam logic [DIVW-1:0]  DIV_A = DIVW'((2 ** OUTW) - 1) << FRACTIONW;
    localparam logic [DATAW-1:0] MINR  = DATAW'(MIN_RANGE);
    localparam logic [PRODW-1:0] RND   = PRODW'(1) << (FRACTIONW - 1);
    localparam logic [PRODW-1:0] OMAXP = PRODW'((2 ** OUTW) - 1);
    localparam logic [ADDRW-1:0] LAST  = ADDRW'(DEPTH - 1);
    localparam logic [DATAW-1:0] POS_MAX = {1'b0, {(DATAW-1){1'b1}}};
    localparam logic [DATAW-1:0] NEG_MAX = {1'b1, {(DATAW-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DIV_GO, S_DIV_WAIT, S_NORM, S_DRAIN} state_t;
    state_t state_q, state_d;

    logic                    start_acc, scan_exit, div_start, div_fin;
    logic                    div_done, div_valid;
    logic [DIVW-1:0]         div_q;
    logic signed [DATAW-1:0] min_q, run_min_q, run_max_q;
    logic [DATAW-1:0]        range_q, o_min_q, o_range_q;
    logic [DIVW-1:0]         scale_q;
    logic                    clip_lo_q, clip_hi_q;
    logic [ADDRW-1:0]        rd_addr_q;
    logic                    rd_done_q, rd_en;
    logic [RD_LAT-1:0]       lat_vld_q;
    logic [ADDRW-1:0]        lat_addr_q [RD_LAT];
    logic                    ret_vld, norm_ret, lat_busy, pipe_empty;
    logic                    s1_vld_q, s2_vld_q, s3_vld_q;
    logic [ADDRW-1:0]        s1_addr_q, s2_addr_q, s3_addr_q;
    logic [DATAW-1:0]        s1_delta_q;
    logic [PRODW-1:0]        s2_prod_q, shifted;
    logic [OUTW-1:0]         s3_data_q, pix;
    logic signed [DATAW:0]   delta;
    logic [DATAW:0]          span;
    logic [DATAW-1:0]        man_range, scan_range;

    assign rd_en      = (state_q == S_SCAN || state_q == S_NORM) && !rd_done_q;
    assign ret_vld    = lat_vld_q[RD_LAT-1];
    assign norm_ret   = ret_vld && (state_q == S_NORM || state_q == S_DRAIN);
    assign lat_busy   = |lat_vld_q;
    assign pipe_empty = !lat_busy && !s1_vld_q && !s2_vld_q && !s3_vld_q;

    // Ranges are computed one bit wider so max-min and data-min cannot overflow.
    assign delta      = $signed({i_rd_data[DATAW-1], i_rd_data}) - $signed({min_q[DATAW-1], min_q});
    assign span       = {run_max_q[DATAW-1], run_max_q} - {run_min_q[DATAW-1], run_min_q};
    assign scan_range = (span < {1'b0, MINR}) ? MINR : span[DATAW-1:0];
    assign man_range  = (i_range < MINR) ? MINR : i_range;
    assign shifted    = s2_prod_q >> FRACTIONW;
    assign pix        = (shifted > OMAXP) ? OMAXP[OUTW-1:0] : shifted[OUTW-1:0];

    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        scan_exit = 1'b0;
        div_start = 1'b0;
        div_fin   = 1'b0;
        case (state_q)
            S_IDLE: if (i_start) begin
                start_acc = 1'b1;
                state_d   = i_auto ? S_SCAN : S_DIV_GO;
            end
            S_SCAN: if (rd_done_q && !lat_busy) begin
                scan_exit = 1'b1;
                state_d   = S_DIV_GO;
            end
            S_DIV_GO: begin
                div_start = 1'b1;
                state_d   = S_DIV_WAIT;
            end
            S_DIV_WAIT: if (div_done) begin
                div_fin = 1'b1;
                state_d = S_NORM;
            end
            S_NORM:  if (rd_done_q) state_d = S_DRAIN;
            S_DRAIN: if (pipe_empty) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            min_q      <= '0;
            range_q    <= '0;
            run_min_q  <= '0;
            run_max_q  <= '0;
            scale_q    <= '0;
            o_min_q    <= '0;
            o_range_q  <= '0;
            clip_lo_q  <= 1'b0;
            clip_hi_q  <= 1'b0;
            rd_addr_q  <= '0;
            rd_done_q  <= 1'b0;
            lat_vld_q  <= '0;
            for (int i = 0; i < RD_LAT; i++) lat_addr_q[i] <= '0;
            s1_vld_q   <= 1'b0;
            s1_addr_q  <= '0;
            s1_delta_q <= '0;
            s2_vld_q   <= 1'b0;
            s2_addr_q  <= '0;
            s2_prod_q  <= '0;
            s3_vld_q   <= 1'b0;
            s3_addr_q  <= '0;
            s3_data_q  <= '0;
        end else begin
            if (start_acc || div_fin) begin
                rd_addr_q <= '0;
                rd_done_q <= 1'b0;
            end else if (rd_en) begin
                if (rd_addr_q == LAST) rd_done_q <= 1'b1;
                else                   rd_addr_q <= rd_addr_q + 1'b1;
            end

            // Request delay line mirrors the RAM latency so each return keeps its address.
            lat_vld_q[0]  <= rd_en;
            lat_addr_q[0] <= rd_addr_q;
            for (int i = 1; i < RD_LAT; i++) begin
                lat_vld_q[i]  <= lat_vld_q[i-1];
                lat_addr_q[i] <= lat_addr_q[i-1];
            end

            if (start_acc) begin
                clip_lo_q <= 1'b0;
                clip_hi_q <= 1'b0;
                run_min_q <= POS_MAX;
                run_max_q <= NEG_MAX;
                if (!i_auto) begin
                    min_q   <= i_min;
                    range_q <= man_range;
                end
            end

            if (state_q == S_SCAN && ret_vld) begin
                if ($signed(i_rd_data) < run_min_q) run_min_q <= $signed(i_rd_data);
                if ($signed(i_rd_data) > run_max_q) run_max_q <= $signed(i_rd_data);
            end

            if (scan_exit) begin
                min_q   <= run_min_q;
                range_q <= scan_range;
            end

            if (div_start) begin
                o_min_q   <= min_q;
                o_range_q <= range_q;
            end

            if (div_fin) scale_q <= div_valid ? div_q : '0;

            s1_vld_q  <= norm_ret;
            s1_addr_q <= lat_addr_q[RD_LAT-1];
            if (norm_ret) begin
                if (delta < 0) begin
                    s1_delta_q <= '0;
                    clip_lo_q  <= 1'b1;
                end else if (delta > $signed({1'b0, range_q})) begin
                    s1_delta_q <= range_q;
                    clip_hi_q  <= 1'b1;
                end else begin
                    s1_delta_q <= delta[DATAW-1:0];
                end
            end

            s2_vld_q  <= s1_vld_q;
            s2_addr_q <= s1_addr_q;
            s2_prod_q <= PRODW'(s1_delta_q) * PRODW'(scale_q) + RND;

            s3_vld_q  <= s2_vld_q;
            s3_addr_q <= s2_addr_q;
            s3_data_q <= pix;
        end
    end

    divu_int #(.WIDTH(DIVW)) u_div (
        .clk_i   (i_clk),
        .rst_i   (~i_rst_n),
        .start_i (div_start),
        .a_i     (DIV_A),
        .b_i     (DIVW'(range_q)),
        .done_o  (div_done),
        .valid_o (div_valid),
        .q_o     (div_q)
    );

    assign o_busy     = (state_q != S_IDLE);
    assign o_done     = (state_q == S_DRAIN) && pipe_empty;
    assign o_rd_valid = rd_en;
    assign o_rd_addr  = rd_addr_q;
    assign o_wr_valid = s3_vld_q;
    assign o_wr_addr  = s3_addr_q;
    assign o_wr_data  = s3_data_q;
    assign o_min      = o_min_q;
    assign o_range    = o_range_q;
    assign o_clip_lo  = clip_lo_q;
    assign o_clip_hi  = clip_hi_q;
endmodule

// File: tb/tb_data_normalizer_auto.sv
// tb/tb_data_normalizer_auto.sv - self-checking bench for data_normalizer_auto
module tb_data_normalizer_auto;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    typedef struct {int cyc; int addr;} rd_t;
    typedef struct {int addr; logic [7:0] data;} exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start1, start3, auto_i, sel3;
    logic [15:0] min_i, range_i;

    logic busy1, done1, rdv1, wrv1, clo1, chi1;
    logic [AW-1:0] rda1, wra1;
    logic [15:0] rdd1, omin1, orng1;
    logic [7:0] wrd1;
    logic busy3, done3, rdv3, wrv3, clo3, chi3;
    logic [AW-1:0] rda3, wra3;
    logic [15:0] rdd3, omin3, orng3;
    logic [7:0] wrd3;

    data_normalizer_auto #(.DEPTH(DEPTH), .RD_LAT(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_auto(auto_i),
        .i_min(min_i), .i_range(range_i), .o_busy(busy1), .o_done(done1),
        .o_rd_valid(rdv1), .o_rd_addr(rda1), .i_rd_data(rdd1),
        .o_wr_valid(wrv1), .o_wr_addr(wra1), .o_wr_data(wrd1),
        .o_min(omin1), .o_range(orng1), .o_clip_lo(clo1), .o_clip_hi(chi1));

    data_normalizer_auto #(.DEPTH(DEPTH), .RD_LAT(3)) u_dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start3), .i_auto(auto_i),
        .i_min(min_i), .i_range(range_i), .o_busy(busy3), .o_done(done3),
        .o_rd_valid(rdv3), .o_rd_addr(rda3), .i_rd_data(rdd3),
        .o_wr_valid(wrv3), .o_wr_addr(wra3), .o_wr_data(wrd3),
        .o_min(omin3), .o_range(orng3), .o_clip_lo(clo3), .o_clip_hi(chi3));

    logic busy, done, rdv, wrv, clo, chi;
    logic [AW-1:0] rda, wra;
    logic [7:0] wrd;
    logic [15:0] omin, orng;
    assign busy = sel3 ? busy3 : busy1;
    assign done = sel3 ? done3 : done1;
    assign rdv  = sel3 ? rdv3 : rdv1;
    assign rda  = sel3 ? rda3 : rda1;
    assign wrv  = sel3 ? wrv3 : wrv1;
    assign wra  = sel3 ? wra3 : wra1;
    assign wrd  = sel3 ? wrd3 : wrd1;
    assign omin = sel3 ? omin3 : omin1;
    assign orng = sel3 ? orng3 : orng1;
    assign clo  = sel3 ? clo3 : clo1;
    assign chi  = sel3 ? chi3 : chi1;

    // frame memory with 1- and 3-cycle read ports
    logic signed [15:0] mem [DEPTH];
    logic [15:0] p1;
    logic [15:0] p3 [3];
    always @(posedge clk) begin
        p1    <= rdv1 ? mem[rda1] : 16'h0;
        p3[0] <= rdv3 ? mem[rda3] : 16'h0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign rdd1 = p1;
    assign rdd3 = p3[2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    exp_t sb [$];
    rd_t  rd_q [$];
    logic [7:0] got [DEPTH];
    int wr_count, done_count, done_cyc, last_wr_cyc;
    logic rdv_prev = 1'b0;
    int m_min, m_rg;
    bit m_clo, m_chi;

    // monitor: read-to-write latency, address carry and scoreboard pop
    always @(negedge clk) begin
        rd_t r;
        exp_t e;
        int lat;
        lat = sel3 ? 6 : 4;
        if (rdv) begin
            if (!rdv_prev) rd_q.delete();
            rd_q.push_back('{cyc, int'(rda)});
        end
        rdv_prev = rdv;
        if (wrv) begin
            wr_count++;
            got[wra] = wrd;
            last_wr_cyc = cyc;
            if (rd_q.size() == 0 || sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write addr=%0d data=%0d", wra, wrd);
            end else begin
                r = rd_q.pop_front();
                e = sb.pop_front();
                checks++;
                if (int'(wra) !== r.addr || int'(wra) !== e.addr) begin
                    errors++;
                    $display("FAIL wr_addr got=%0d rd_addr=%0d expected=%0d", wra, r.addr, e.addr);
                end
                checks++;
                if (cyc - r.cyc !== lat) begin
                    errors++;
                    $display("FAIL wr_latency got=%0d expected=%0d", cyc - r.cyc, lat);
                end
                checks++;
                if (wrd !== e.data) begin
                    errors++;
                    $display("FAIL wr_data addr=%0d got=%0d expected=%0d", wra, wrd, e.data);
                end
            end
        end
        if (done) begin
            done_count++;
            done_cyc = cyc;
        end
    end

    function automatic logic [7:0] ref_pix(input int d, input int mn, input int rg, input int sc);
        longint delta, p;
        delta = d - mn;
        if (delta < 0) delta = 0;
        if (delta > rg) delta = rg;
        p = (delta * sc + 2048) >>> 12;
        if (p > 255) p = 255;
        return p[7:0];
    endfunction

    task automatic build_expect(input bit a, input int mn, input int rg);
        int mx, sc, d;
        if (a) begin
            m_min = 32767; mx = -32768;
            for (int i = 0; i < DEPTH; i++) begin
                d = int'(mem[i]);
                if (d < m_min) m_min = d;
                if (d > mx) mx = d;
            end
            m_rg = mx - m_min;
        end else begin
            m_min = mn;
            m_rg  = rg;
        end
        if (m_rg < 16) m_rg = 16;
        sc = (255 * 4096) / m_rg;
        m_clo = 0; m_chi = 0;
        sb.delete();
        for (int i = 0; i < DEPTH; i++) begin
            d = int'(mem[i]);
            if (d < m_min) m_clo = 1;
            if (d - m_min > m_rg) m_chi = 1;
            sb.push_back('{i, ref_pix(d, m_min, m_rg, sc)});
        end
    endtask

    task automatic start_frame(input bit s3, input bit a, input int mn, input int rg);
        sel3 = s3;
        build_expect(a, mn, rg);
        wr_count = 0; done_count = 0; done_cyc = -1; last_wr_cyc = -1;
        @(posedge clk); #1;
        auto_i = a; min_i = 16'(mn); range_i = 16'(rg);
        if (s3) start3 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start3 = 1'b0;
        auto_i = ~a; min_i = 16'h1234; range_i = 16'h0003;
    endtask

    task automatic wait_done();
        int n = 0;
        while (n < 3000) begin
            @(negedge clk);
            if (done) break;
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL done_timeout got=no_done expected=done_within_3000");
        end
        @(negedge clk);
    endtask

    task automatic check_frame_end();
        checks++;
        if (wr_count !== DEPTH || sb.size() !== 0) begin
            errors++;
            $display("FAIL write_count got=%0d left=%0d expected=%0d", wr_count, sb.size(), DEPTH);
        end
        checks++;
        if (done_count !== 1 || done_cyc !== last_wr_cyc + 1) begin
            errors++;
            $display("FAIL done_timing got=count%0d cyc%0d expected=count1 cyc%0d", done_count, done_cyc, last_wr_cyc + 1);
        end
    endtask

    task automatic check_scaling(input int emin, input int erng, input bit elo, input bit ehi);
        logic [15:0] e16, r16;
        e16 = 16'(emin); r16 = 16'(erng);
        checks++;
        if (omin !== e16 || orng !== r16) begin
            errors++;
            $display("FAIL min_range got=%0d/%0d expected=%0d/%0d", $signed(omin), orng, emin, erng);
        end
        checks++;
        if (clo !== elo || chi !== ehi) begin
            errors++;
            $display("FAIL clip_flags got=%b%b expected=%b%b", clo, chi, elo, ehi);
        end
    endtask

    task automatic check_pix(input int addr, input logic [7:0] ev);
        checks++;
        if (got[addr] !== ev) begin
            errors++;
            $display("FAIL pixel[%0d] got=%0d expected=%0d", addr, got[addr], ev);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; sel3 = 1'b0;
        auto_i = 1'b0; min_i = '0; range_i = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy1, done1, rdv1, wrv1, clo1, chi1, busy3, done3, rdv3, wrv3, clo3, chi3} !== 12'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b expected=0", {busy1, done1, rdv1, wrv1, clo1, chi1, busy3, done3, rdv3, wrv3, clo3, chi3});
        end
        checks++;
        if ({omin1, orng1, omin3, orng3} !== 64'b0) begin
            errors++;
            $display("FAIL reset_minrange got=%h expected=0", {omin1, orng1, omin3, orng3});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy1 !== 1'b0 || rdv1 !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got=%b%b expected=00", busy1, rdv1);
        end
    endtask

    task automatic test_manual();
        for (int i = 0; i < DEPTH; i++) mem[i] = (i % 3 == 0) ? -16'sd100 : (i % 3 == 1) ? 16'sd100 : 16'sd300;
        start_frame(0, 0, -100, 400);
        wait_done();
        check_frame_end();
        check_scaling(-100, 400, 0, 0);
        check_pix(0, 8'd0);
        check_pix(1, 8'd127);
        check_pix(2, 8'd255);
    endtask

    task automatic test_clip();
        for (int i = 0; i < DEPTH; i++) mem[i] = (i % 2 == 0) ? -16'sd200 : 16'sd500;
        start_frame(0, 0, -100, 400);
        wait_done();
        check_frame_end();
        check_scaling(-100, 400, 1, 1);
        check_pix(0, 8'd0);
        check_pix(1, 8'd255);
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'sd0;
        start_frame(0, 0, -100, 400);
        repeat (3) @(negedge clk);
        checks++;
        if (clo !== 1'b0 || chi !== 1'b0) begin
            errors++;
            $display("FAIL clip_clear got=%b%b expected=00", clo, chi);
        end
        wait_done();
        check_frame_end();
    endtask

    task automatic test_auto();
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'sd1000;
        mem[5] = 16'sd900;
        mem[40] = 16'sd1200;
        start_frame(0, 1, 7, 9);
        wait_done();
        check_frame_end();
        check_scaling(900, 300, 0, 0);
        check_pix(0, 8'd85);
        check_pix(5, 8'd0);
        check_pix(40, 8'd255);
    endtask

    task automatic test_flat();
        int nz = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'sd500;
        start_frame(0, 1, 0, 0);
        wait_done();
        check_frame_end();
        check_scaling(500, 16, 0, 0);
        for (int i = 0; i < DEPTH; i++) if (got[i] !== 8'd0) nz++;
        checks++;
        if (nz !== 0) begin
            errors++;
            $display("FAIL flat_zero got=%0d_nonzero expected=0", nz);
        end
    endtask

    task automatic test_rdlat3();
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
        start_frame(1, 1, 0, 0);
        repeat (10) @(posedge clk);
        #1 start3 = 1'b1;
        @(posedge clk); #1 start3 = 1'b0;
        repeat (100) @(posedge clk);
        #1 start3 = 1'b1;
        @(posedge clk); #1 start3 = 1'b0;
        wait_done();
        check_frame_end();
        check_scaling(m_min, m_rg, m_clo, m_chi);
        repeat (20) @(negedge clk);
        checks++;
        if (busy3 !== 1'b0 || wr_count !== DEPTH) begin
            errors++;
            $display("FAIL start_while_busy got=busy%b writes%0d expected=busy0 writes%0d", busy3, wr_count, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom_range(0, 8000) - 4000);
        start_frame(1, 0, -1000, 3000);
        wait_done();
        check_frame_end();
        check_scaling(-1000, 3000, m_clo, m_chi);
    endtask

    task automatic test_reset_abort();
        int n = 0;
        int wc;
        for (int i = 0; i < DEPTH; i++) mem[i] = (i % 3 == 0) ? -16'sd100 : (i % 3 == 1) ? 16'sd100 : 16'sd300;
        start_frame(0, 0, -100, 400);
        while (n < 3000) begin
            @(negedge clk);
            if (rdv1 && rda1 == 6'd20) break;
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL abort_reach got=no_addr20 expected=addr20");
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({wrv1, busy1, rdv1} !== 3'b0 || omin1 !== 16'h0 || orng1 !== 16'h0) begin
            errors++;
            $display("FAIL async_reset got=%b%b%b %h %h expected=000 0 0", wrv1, busy1, rdv1, omin1, orng1);
        end
        sb.delete();
        rd_q.delete();
        wc = wr_count;
        repeat (4) @(negedge clk);
        checks++;
        if (wr_count !== wc || done_count !== 0) begin
            errors++;
            $display("FAIL abort_quiet got=writes%0d done%0d expected=writes%0d done0", wr_count, done_count, wc);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        start_frame(0, 0, -100, 400);
        wait_done();
        check_frame_end();
        check_scaling(-100, 400, 0, 0);
        check_pix(1, 8'd127);
    endtask

    initial begin
        test_reset();
        test_manual();
        test_clip();
        test_auto();
        test_flat();
        test_rdlat3();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_normalizer_auto.md
Name: data_normalizer_auto

Overview:
- Frame-level normaliser for the thermal pipeline. It maps signed DATAW-bit samples held in a frame memory to unsigned OUTW-bit pixels, for example MLX90640 32x24 raw data to 8-bit display values.
- Generalises the earlier fixed normaliser in three ways:
  - selectable auto mode, where a scan pass finds the frame min/max;
  - configurable output width and read latency;
  - two-sided clamping with rounding.
- Sits between the frame RAM read port and the display/colour-map RAM write port.

Parameters:
- DATAW, 16, sample width (signed).
- DEPTH, 768, samples per frame; addresses 0..DEPTH-1. ADDRW = $clog2(DEPTH).
- OUTW, 8, output pixel width. OMAX = 2**OUTW-1.
- FRACTIONW, 12, fractional bits of the scale factor. DIVW = OUTW+FRACTIONW, and DIVW must be >= DATAW.
- RD_LAT, 1, cycles from o_rd_valid/o_rd_addr to i_rd_data valid (1..4).
- MIN_RANGE, 16, floor applied to the range; prevents divide-by-zero and noise blow-up.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  start a frame; sampled only in IDLE
- i_auto  in  1  latched at start: 1 = scan frame for min/range, 0 = use i_min/i_range
- i_min  in  DATAW  signed manual minimum
- i_range  in  DATAW  unsigned manual range
- o_busy  out  1  high from accepted start until o_done
- o_done  out  1  one-cycle pulse after the last write
- o_rd_valid  out  1  read request
- o_rd_addr  out  ADDRW  read address
- i_rd_data  in  DATAW  read data, RD_LAT cycles after the request
- o_wr_valid  out  1  write strobe
- o_wr_addr  out  ADDRW  write address, equal to the originating read address
- o_wr_data  out  OUTW  normalised pixel
- o_min  out  DATAW  min used for the current/last frame
- o_range  out  DATAW  range used, after the MIN_RANGE floor
- o_clip_lo  out  1  sticky: some sample was < min this frame
- o_clip_hi  out  1  sticky: some sample was > min+range this frame

Behaviour:
- Reset (async, i_rst_n=0):
  - State goes to IDLE.
  - All outputs are 0 immediately, including o_min, o_range and the clip flags.
  - Pipeline valids are cleared.
  - The internal divu_int (WIDTH=DIVW) gets rst = ~i_rst_n.
- IDLE:
  - On i_start, latch i_auto and clear the clip flags.
  - If auto: go to SCAN, with running min = most positive and running max = most negative.
  - If manual: latch min=i_min and range=max(i_range, MIN_RANGE), then go to DIV.
- SCAN:
  - Issue reads at addresses 0..DEPTH-1, one per cycle, back-to-back.
  - Returned data, delayed RD_LAT cycles, updates the signed running min/max.
  - After the last return, go to DIV with min=running min and range=max(max-min, MIN_RANGE). The subtraction is done at DATAW+1 bits; the result fits in unsigned DATAW.
- DIV:
  - Pulse divider start for one cycle.
  - Operands: a = OMAX<<FRACTIONW, b = range zero-extended to DIVW.
  - On done & valid: scale = result.
  - On done & !valid: scale = 0, so the frame writes all zeros.
  - Then go to NORM.
- NORM:
  - Issue reads 0..DEPTH-1 back-to-back.
  - Pipeline after data return:
    - Stage 1: delta = signed(data) - min at DATAW+1 bits. If delta < 0, use 0 and set clip_lo. If delta > range, use range and set clip_hi.
    - Stage 2: prod = delta * scale + 2**(FRACTIONW-1). This is round-half-up.
    - Stage 3: o_wr_data = min(prod>>FRACTIONW, OMAX). The saturation is defensive and unreachable with correct arithmetic.
  - Latency from o_rd_valid to matching o_wr_valid is RD_LAT+3 cycles.
  - o_wr_addr is carried through the pipeline; it is not recomputed from the read counter.
- DRAIN:
  - Wait until the pipeline is empty.
  - Pulse o_done for one cycle in the cycle after the last o_wr_valid, then return to IDLE.
- o_busy is 0 only in IDLE.
- i_start while busy is ignored.
- i_start in the same cycle as o_done is ignored; the next start is accepted from IDLE.
- i_min, i_range and i_auto are don't-care except in the start cycle.
- o_min and o_range update when the divider is started and hold until the next frame.
- Exactly DEPTH writes per frame, each address written exactly once, in ascending order, with no gaps during NORM.
- Reset asserted mid-SCAN/NORM aborts the frame. No further writes and no o_done.

Test Plan:
- Manual mode (DEPTH=64, RD_LAT=1), min=-100, range=400 (scale=2611). Data -100, 100, 300 -> 0, 127, 255. Frame of 64 writes with addresses 0..63; o_done occurs 1 cycle after the last write; o_wr_valid comes 4 cycles after the matching o_rd_valid.
- Manual clipping: same settings, data -200 and 500 -> 0 and 255. o_clip_lo=1 and o_clip_hi=1 after the frame; both are cleared by the next start.
- Auto mode: frame of 1000s with one 900 and one 1200. Expect o_min=900, o_range=300, scale=3481. Outputs: 1000->85, 900->0, 1200->255. No clip flags.
- Flat frame in auto mode, all samples 500: o_range=16 (MIN_RANGE floor), all outputs 0, no clips.
- RD_LAT=3 build with random data: every o_wr_addr matches its read address and the value matches the reference model. i_start pulses while busy produce no extra frame.
- Assert i_rst_n=0 mid-NORM at address 20: o_wr_valid, o_busy, o_min and o_range go to 0 asynchronously. After release, a new start runs a full, correct frame.
